// File: rtl/variable_pkg.sv
// Shared game-wide constants and helpers.
//   PLAYER_1 / PLAYER_2 : two-bit player codes used on current_player and winner.
//   opponent()          : the other player's code.
//   lives_dec_sat()     : lives minus one, floored at zero.
package variable_pkg;

  localparam logic [1:0] PLAYER_1 = 2'b01;
  localparam logic [1:0] PLAYER_2 = 2'b10;

  function automatic logic [1:0] opponent(input logic [1:0] player);
    return (player == PLAYER_1) ? PLAYER_2 : PLAYER_1;
  endfunction

  function automatic logic [1:0] lives_dec_sat(input logic [1:0] lives);
    return (lives == 2'd0) ? 2'd0 : lives - 2'd1;
  endfunction

endpackage

// File: rtl/hit_box_check.sv
// Hit-box test for one player's box.
// A point is inside the box when it is at or below the top edge (y >= target_y_i) and
// its x lies in [x_min_i, x_max_i], with both bounds inclusive.
// Ports:
//   xpos_i, ypos_i   projectile position
//   x_min_i, x_max_i horizontal window of the box
//   target_y_i       top edge of the box
//   in_box_o         high while the point is inside the box (combinational)
module hit_box_check (
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  input  logic [11:0] x_min_i,
  input  logic [11:0] x_max_i,
  input  logic [11:0] target_y_i,
  output logic        in_box_o
);

  assign in_box_o = (ypos_i >= target_y_i) && (xpos_i >= x_min_i) && (xpos_i <= x_max_i);

endmodule

// File: rtl/turn_ctrl.sv
// Turn controller for a two-player throwing game.
// A click in IDLE launches a throw. During FLIGHT the projectile is watched until it hits
// the opponent, lands, or times out. RESOLVE then charges any damage, SWITCH waits before
// handing the turn over, and OVER holds the result until reset.
// Ports:
//   clk60MHz, rst        clock, asynchronous active-high reset
//   mouse_left           synchronised left-button level
//   xpos_prebuff/ypos_.. projectile position from the trajectory stages
//   throw_flag           one-cycle pulse starting a throw
//   end_throw            one-cycle pulse ending a throw (RESOLVE)
//   hit                  one-cycle pulse with end_throw when the opponent was struck
//   current_player       PLAYER_1 / PLAYER_2
//   lives_p1, lives_p2   remaining lives
//   game_over, winner    final result (winner is 2'b00 until game_over)
module turn_ctrl
  import variable_pkg::*;
#(
  parameter int unsigned GROUND_Y       = 768,
  parameter int unsigned TARGET_Y       = 650,
  parameter int unsigned P1_X_MIN       = 40,
  parameter int unsigned P1_X_MAX       = 200,
  parameter int unsigned P2_X_MIN       = 824,
  parameter int unsigned P2_X_MAX       = 984,
  parameter int unsigned SWITCH_DELAY   = 30_000_000,
  parameter int unsigned FLIGHT_TIMEOUT = 120_000_000,
  parameter int unsigned START_LIVES    = 3
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] xpos_prebuff,
  input  logic [11:0] ypos_prebuff,
  output logic        throw_flag,
  output logic        end_throw,
  output logic [1:0]  current_player,
  output logic        hit,
  output logic [1:0]  lives_p1,
  output logic [1:0]  lives_p2,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int unsigned TimeoutW = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;
  localparam int unsigned SwitchW  = (SWITCH_DELAY > 1) ? $clog2(SWITCH_DELAY) : 1;

  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(FLIGHT_TIMEOUT - 1);
  localparam logic [SwitchW-1:0]  SwitchLast  = SwitchW'(SWITCH_DELAY - 1);
  localparam logic [11:0]         GroundY     = 12'(GROUND_Y);
  localparam logic [11:0]         TargetY     = 12'(TARGET_Y);
  localparam logic [1:0]          StartLives  = 2'(START_LIVES);

  typedef enum logic [2:0] {
    StIdle,
    StFlight,
    StResolve,
    StSwitch,
    StOver
  } state_e;

  state_e              state_q, state_d;
  logic                mouse_prev_q;
  logic                armed_q, armed_d;
  logic                hit_r_q, hit_r_d;
  logic [TimeoutW-1:0] tcnt_q, tcnt_d;
  logic [SwitchW-1:0]  scnt_q, scnt_d;
  logic [1:0]          player_q, player_d;
  logic [1:0]          lives_p1_q, lives_p1_d;
  logic [1:0]          lives_p2_q, lives_p2_d;
  logic                throw_flag_q, throw_flag_d;
  logic                end_throw_q, end_throw_d;
  logic                hit_q, hit_d;
  logic                game_over_q, game_over_d;
  logic [1:0]          winner_q, winner_d;

  // Opponent's hit box follows whose turn it is.
  logic [11:0] opp_x_min, opp_x_max;
  logic        in_box;
  logic [1:0]  opp_lives, opp_lives_new;

  assign opp_x_min = (player_q == PLAYER_1) ? 12'(P2_X_MIN) : 12'(P1_X_MIN);
  assign opp_x_max = (player_q == PLAYER_1) ? 12'(P2_X_MAX) : 12'(P1_X_MAX);

  hit_box_check u_hit_box_check (
    .xpos_i     (xpos_prebuff),
    .ypos_i     (ypos_prebuff),
    .x_min_i    (opp_x_min),
    .x_max_i    (opp_x_max),
    .target_y_i (TargetY),
    .in_box_o   (in_box)
  );

  assign opp_lives     = (player_q == PLAYER_1) ? lives_p2_q : lives_p1_q;
  assign opp_lives_new = hit_r_q ? lives_dec_sat(opp_lives) : opp_lives;

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    hit_r_d      = hit_r_q;
    tcnt_d       = tcnt_q;
    scnt_d       = scnt_q;
    player_d     = player_q;
    lives_p1_d   = lives_p1_q;
    lives_p2_d   = lives_p2_q;
    throw_flag_d = 1'b0;
    end_throw_d  = 1'b0;
    hit_d        = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;

    unique case (state_q)
      StIdle: begin
        if (mouse_left && !mouse_prev_q) begin
          throw_flag_d = 1'b1;
          armed_d      = 1'b0;
          tcnt_d       = '0;
          state_d      = StFlight;
        end
      end

      StFlight: begin
        tcnt_d = tcnt_q + TimeoutW'(1);
        // The trajectory stage idles at y=769; nothing counts until y has left the ground.
        if (ypos_prebuff < GroundY) begin
          armed_d = 1'b1;
        end
        // Outcomes register with the state change so the pulses line up with RESOLVE.
        if (armed_q && in_box) begin
          hit_r_d     = 1'b1;
          hit_d       = 1'b1;
          end_throw_d = 1'b1;
          state_d     = StResolve;
        end else if ((armed_q && (ypos_prebuff >= GroundY)) || (tcnt_q == TimeoutLast)) begin
          hit_r_d     = 1'b0;
          end_throw_d = 1'b1;
          state_d     = StResolve;
        end
      end

      StResolve: begin
        if (player_q == PLAYER_1) begin
          lives_p2_d = opp_lives_new;
        end else begin
          lives_p1_d = opp_lives_new;
        end
        scnt_d = '0;
        if (opp_lives_new == 2'd0) begin
          game_over_d = 1'b1;
          winner_d    = player_q;
          state_d     = StOver;
        end else begin
          state_d = StSwitch;
        end
      end

      StSwitch: begin
        if (scnt_q == SwitchLast) begin
          player_d = opponent(player_q);
          state_d  = StIdle;
        end else begin
          scnt_d = scnt_q + SwitchW'(1);
        end
      end

      StOver: begin
        state_d = StOver;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mouse_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      hit_r_q      <= 1'b0;
      tcnt_q       <= '0;
      scnt_q       <= '0;
      player_q     <= PLAYER_1;
      lives_p1_q   <= StartLives;
      lives_p2_q   <= StartLives;
      throw_flag_q <= 1'b0;
      end_throw_q  <= 1'b0;
      hit_q        <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      mouse_prev_q <= mouse_left;
      armed_q      <= armed_d;
      hit_r_q      <= hit_r_d;
      tcnt_q       <= tcnt_d;
      scnt_q       <= scnt_d;
      player_q     <= player_d;
      lives_p1_q   <= lives_p1_d;
      lives_p2_q   <= lives_p2_d;
      throw_flag_q <= throw_flag_d;
      end_throw_q  <= end_throw_d;
      hit_q        <= hit_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign throw_flag     = throw_flag_q;
  assign end_throw      = end_throw_q;
  assign hit            = hit_q;
  assign current_player = player_q;
  assign lives_p1       = lives_p1_q;
  assign lives_p2       = lives_p2_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;

endmodule
